// File: rtl/data_interpolation_pkg.sv
// rtl/data_interpolation_pkg.sv - shared state and mode definitions for the upsampler
package data_interpolation_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    localparam logic MODE_HOLD   = 1'b0;
    localparam logic MODE_ZSTUFF = 1'b1;

endpackage

// File: rtl/interp_sample_slot.sv
// rtl/interp_sample_slot.sv - active/pending sample+control buffer with registered ready
module interp_sample_slot #(
    parameter int DATA_WIDTH = 12,
    parameter int REG_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [REG_WIDTH-1:0]  factor,
    input  logic                  mode,
    input  logic                  load_active,
    input  logic                  promote,
    input  logic                  load_pending,
    output logic [DATA_WIDTH-1:0] act_data,
    output logic [REG_WIDTH-1:0]  act_factor,
    output logic                  act_mode,
    output logic                  pending_full,
    output logic                  ready
);

    logic [DATA_WIDTH-1:0] pend_data;
    logic [REG_WIDTH-1:0]  pend_factor;
    logic                  pend_mode;
    logic                  pending_next;

    always_comb begin
        pending_next = pending_full;
        if (load_pending) begin
            pending_next = 1'b1;
        end else if (promote) begin
            pending_next = 1'b0;
        end
    end

    // ready tracks the next pending occupancy so a promote frees the slot on the following cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_data     <= '0;
            act_factor   <= '0;
            act_mode     <= 1'b0;
            pend_data    <= '0;
            pend_factor  <= '0;
            pend_mode    <= 1'b0;
            pending_full <= 1'b0;
            ready        <= 1'b0;
        end else begin
            pending_full <= pending_next;
            ready        <= !pending_next;
            if (load_active) begin
                act_data   <= data;
                act_factor <= factor;
                act_mode   <= mode;
            end else if (promote) begin
                act_data   <= pend_data;
                act_factor <= pend_factor;
                act_mode   <= pend_mode;
            end
            if (load_pending) begin
                pend_data   <= data;
                pend_factor <= factor;
                pend_mode   <= mode;
            end
        end
    end

endmodule

// File: rtl/data_interpolation.sv
// rtl/data_interpolation.sv - upsampler emitting interp_reg+1 hold or zero-stuffed beats per sample
module data_interpolation
    import data_interpolation_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = 12,
    parameter int DATA_OUT_WIDTH = 12,
    parameter int DATA_REG_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_REG_WIDTH-1:0] interp_reg,
    input  logic                      mode_reg,
    input  logic [DATA_IN_WIDTH-1:0]  in_data,
    input  logic                      in_data_valid,
    output logic                      in_data_ready,
    output logic [DATA_OUT_WIDTH-1:0] out_data,
    output logic                      out_data_valid,
    input  logic                      out_data_ready,
    output logic                      busy
);

    state_t                      state, state_next;
    logic [DATA_REG_WIDTH-1:0]   cnt, cnt_next;
    logic [DATA_IN_WIDTH-1:0]    act_data;
    logic [DATA_REG_WIDTH-1:0]   act_factor;
    logic                        act_mode;
    logic                        pending_full;
    logic                        load_active, promote, load_pending;
    logic                        accept, beat_done, last_beat;

    assign accept    = in_data_valid & in_data_ready;
    assign beat_done = (state == ST_EMIT) & out_data_ready;
    assign last_beat = (cnt == act_factor);

    interp_sample_slot #(
        .DATA_WIDTH (DATA_IN_WIDTH),
        .REG_WIDTH  (DATA_REG_WIDTH)
    ) u_slot (
        .clk          (clk),
        .rst_n        (rst_n),
        .data         (in_data),
        .factor       (interp_reg),
        .mode         (mode_reg),
        .load_active  (load_active),
        .promote      (promote),
        .load_pending (load_pending),
        .act_data     (act_data),
        .act_factor   (act_factor),
        .act_mode     (act_mode),
        .pending_full (pending_full),
        .ready        (in_data_ready)
    );

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        load_active  = 1'b0;
        promote      = 1'b0;
        load_pending = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    load_active = 1'b1;
                    cnt_next    = '0;
                    state_next  = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (beat_done && last_beat) begin
                    // pending wins over a same-cycle input; ready is low whenever pending is full
                    cnt_next = '0;
                    if (pending_full) begin
                        promote = 1'b1;
                    end else if (accept) begin
                        load_active = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    if (beat_done) begin
                        cnt_next = cnt + DATA_REG_WIDTH'(1);
                    end
                    load_pending = accept;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    assign out_data_valid = (state == ST_EMIT);
    assign out_data = (out_data_valid && (cnt == '0 || act_mode == MODE_HOLD)) ?
                      DATA_OUT_WIDTH'(act_data) : '0;
    assign busy = out_data_valid | pending_full;

endmodule

// File: tb/tb_data_interpolation.sv
// tb/tb_data_interpolation.sv - randomized self-checking bench against a burst-queue reference model
module tb_data_interpolation;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] interp_reg = '0;
    logic        mode_reg = 1'b0;
    logic [11:0] in_data = '0;
    logic        in_data_valid = 1'b0;
    logic        in_data_ready;
    logic [11:0] out_data;
    logic        out_data_valid;
    logic        out_data_ready = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    data_interpolation dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .interp_reg     (interp_reg),
        .mode_reg       (mode_reg),
        .in_data        (in_data),
        .in_data_valid  (in_data_valid),
        .in_data_ready  (in_data_ready),
        .out_data       (out_data),
        .out_data_valid (out_data_valid),
        .out_data_ready (out_data_ready),
        .busy           (busy)
    );

    // one entry per accepted sample still owed beats; size is the slot occupancy
    typedef struct {
        logic [11:0] s;
        logic        m;
        logic [32:0] n;
        logic [32:0] idx;
    } burst_t;

    burst_t      q[$];
    int          checks = 0;
    int          failures = 0;
    int          accepted = 0;
    logic        just_reset = 1'b0;
    logic        stalled = 1'b0;
    logic [11:0] held = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic evaluate();
        logic        exp_ready;
        logic [11:0] exp_d;
        burst_t      b;
        exp_ready = !just_reset && (q.size() < 2);
        chk("in_ready", 64'(in_data_ready), 64'(exp_ready));
        chk("out_valid", 64'(out_data_valid), 64'(q.size() > 0));
        chk("busy", 64'(busy), 64'(q.size() > 0));
        if (stalled && out_data_valid) chk("stall_hold", 64'(out_data), 64'(held));
        if (q.size() > 0) begin
            b = q[0];
            exp_d = (b.idx == 0 || !b.m) ? b.s : 12'h0;
            chk("out_data", 64'(out_data), 64'(exp_d));
            if (out_data_ready) begin
                b.idx = b.idx + 33'd1;
                if (b.idx == b.n) void'(q.pop_front());
                else q[0] = b;
            end
        end
        stalled = out_data_valid && !out_data_ready;
        held = out_data;
        if (in_data_valid && exp_ready) begin
            q.push_back('{in_data, mode_reg, {1'b0, interp_reg} + 33'd1, 33'd0});
            accepted++;
        end
        just_reset = 1'b0;
    endtask

    task automatic step(input logic v, input logic [11:0] d, input logic ordy);
        in_data_valid = v;
        in_data = d;
        out_data_ready = ordy;
        @(negedge clk);
        evaluate();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_data_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        stalled = 1'b0;
        just_reset = 1'b1;
        chk("rst_out_valid", 64'(out_data_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_data_ready), 64'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 500) begin
            step(1'b0, 12'h0, 1'b1);
            n++;
        end
        chk("drain_done", 64'(q.size()), 64'd0);
        step(1'b0, 12'h0, 1'b1);
    endtask

    initial begin
        int guard;
        int start;
        do_reset();
        step(1'b0, 12'h0, 1'b1);
        step(1'b0, 12'h0, 1'b1);

        // single held burst of four
        interp_reg = 32'd3; mode_reg = 1'b0;
        step(1'b1, 12'hABC, 1'b1);
        drain();

        // back-to-back zero-stuffed samples
        interp_reg = 32'd2; mode_reg = 1'b1;
        step(1'b1, 12'h111, 1'b1);
        step(1'b1, 12'h222, 1'b1);
        drain();

        // pass-through streaming
        interp_reg = 32'd0; mode_reg = 1'b0;
        for (int i = 0; i < 100; i++) step(1'b1, 12'($urandom), 1'b1);
        drain();

        // random backpressure and input gaps, both modes
        for (int pass = 0; pass < 2; pass++) begin
            interp_reg = 32'd1; mode_reg = pass[0];
            start = accepted;
            guard = 0;
            while (accepted - start < 100 && guard < 3000) begin
                step(($urandom % 10) < 7, 12'($urandom), 1'($urandom));
                guard++;
            end
            chk("rand_accept_budget", 64'(guard < 3000), 64'd1);
            drain();
        end

        // factor change mid-burst only affects later samples
        interp_reg = 32'd3; mode_reg = 1'b0;
        step(1'b1, 12'h5A5, 1'b1);
        step(1'b0, 12'h0, 1'b1);
        interp_reg = 32'd1;
        step(1'b0, 12'h0, 1'b1);
        step(1'b1, 12'h3C3, 1'b1);
        drain();

        // reset during beat 2 with a sample pending
        interp_reg = 32'd3; mode_reg = 1'b0;
        step(1'b1, 12'h777, 1'b1);
        step(1'b1, 12'h888, 1'b1);
        step(1'b0, 12'h0, 1'b1);
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 12'h0, 1'b1);

        // maximum factor: counter runs without wrapping early
        interp_reg = 32'hFFFF_FFFF; mode_reg = 1'b1;
        step(1'b1, 12'h9E1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 12'($urandom), 1'($urandom));
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 12'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
